// File: rtl/handshaked_reg_pipe.sv
// Valid/ready register pipeline: LATENCY stages, full throughput, backpressure and
// bubble collapsing. Ready ripples combinationally from the output end back to a_rd.
module handshaked_reg_pipe #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned LATENCY    = 2,
  localparam int unsigned OCC_WIDTH = $clog2(LATENCY + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic                  a_vld,
  output logic                  a_rd,
  output logic [DATA_WIDTH-1:0] b,
  output logic                  b_vld,
  input  logic                  b_rd,
  output logic [OCC_WIDTH-1:0]  occupancy
);

  logic [DATA_WIDTH-1:0] d_q [LATENCY];
  logic [LATENCY-1:0]    v_q;
  logic [LATENCY-1:0]    rdy;

  // A stage can load when it is empty or the stage ahead of it is moving.
  always_comb begin
    rdy = '0;
    rdy[LATENCY-1] = ~v_q[LATENCY-1] | b_rd;
    for (int i = int'(LATENCY) - 2; i >= 0; i--) begin
      rdy[i] = ~v_q[i] | rdy[i+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        d_q[i] <= '0;
      end
      v_q <= '0;
    end else begin
      // Data is loaded even when the incoming valid is low; it is don't-care then.
      if (rdy[0]) begin
        d_q[0] <= a;
        v_q[0] <= a_vld;
      end
      for (int i = 1; i < int'(LATENCY); i++) begin
        if (rdy[i]) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < int'(LATENCY); i++) begin
      occupancy = occupancy + OCC_WIDTH'(v_q[i]);
    end
  end

  assign a_rd  = rdy[0] & rst_n;
  assign b     = d_q[LATENCY-1];
  assign b_vld = v_q[LATENCY-1];

endmodule
